// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM that sequences fetch, decode and
// the per-class execute/writeback steps, plus a retired-instruction counter.
module multicycle_controller #(
    parameter int CNT_W           = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       f3,
    input  logic             f7,
    input  logic             zero,
    output logic             pcWrite,
    output logic             adrSrc,
    output logic             memWrite,
    output logic             irWrite,
    output logic [1:0]       resultSrc,
    output logic [2:0]       ALUControl,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       inmSrc,
    output logic             regWrite,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             dec_illegal;
    logic             alu_f3_ok;
    logic [1:0]       alu_op;

    // Encoding legality as seen by DECODE; only funct3 values the ALU decode knows are legal.
    always_comb begin
        alu_f3_ok   = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
        dec_illegal = 1'b0;
        case (op)
            OP_LW, OP_SW: dec_illegal = (f3 != 3'b010);
            OP_R, OP_I:   dec_illegal = !alu_f3_ok;
            OP_BEQ:       dec_illegal = (f3 != 3'b000);
            OP_JAL:       dec_illegal = 1'b0;
            default:      dec_illegal = 1'b1;
        endcase
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                if (dec_illegal)
                    state_d = TRAP_ON_ILLEGAL ? TRAP : FETCH;
                else begin
                    case (op)
                        OP_LW, OP_SW: state_d = MEMADR;
                        OP_R:         state_d = EXECR;
                        OP_I:         state_d = EXECI;
                        OP_BEQ:       state_d = BEQ;
                        default:      state_d = JAL;
                    endcase
                end
            end
            MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;
        endcase
    end

    // Per-state datapath controls; enables are held off while reset is low.
    always_comb begin
        pcWrite   = 1'b0;
        adrSrc    = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        resultSrc = 2'b00;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        alu_op    = 2'b00;
        regWrite  = 1'b0;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                irWrite = 1'b1; aluSrcB = 2'b10; resultSrc = 2'b10; pcWrite = 1'b1;
            end
            DECODE:   begin aluSrcA = 2'b01; aluSrcB = 2'b01; end
            MEMADR:   begin aluSrcA = 2'b10; aluSrcB = 2'b01; end
            MEMREAD:  adrSrc = 1'b1;
            MEMWB:    begin resultSrc = 2'b01; regWrite = 1'b1; retire = 1'b1; end
            MEMWRITE: begin adrSrc = 1'b1; memWrite = 1'b1; retire = 1'b1; end
            EXECR:    begin aluSrcA = 2'b10; alu_op = 2'b10; end
            EXECI:    begin aluSrcA = 2'b10; aluSrcB = 2'b01; alu_op = 2'b10; end
            ALUWB:    begin regWrite = 1'b1; retire = 1'b1; end
            BEQ:      begin aluSrcA = 2'b10; alu_op = 2'b01; pcWrite = zero; retire = 1'b1; end
            JAL:      begin aluSrcA = 2'b01; aluSrcB = 2'b10; pcWrite = 1'b1; end
            TRAP:     illegal = 1'b1;
            default:  ;
        endcase
        if (!reset) begin
            pcWrite  = 1'b0;
            irWrite  = 1'b0;
            regWrite = 1'b0;
            memWrite = 1'b0;
            retire   = 1'b0;
        end
    end

    // ALU operation select; subtract on f7 only for register-register ops (op[5]).
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (f3)
                    3'b000:  ALUControl = (op[5] && f7) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        case (op)
            OP_SW:   inmSrc = 2'b01;
            OP_BEQ:  inmSrc = 2'b10;
            OP_JAL:  inmSrc = 2'b11;
            default: inmSrc = 2'b00;
        endcase
    end

    // Retired count advances on the final state of every legal instruction.
    always_comb instret_d = instret_q + CNT_W'(retire);

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through its state sequence and checks every control output per cycle.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, zero;
    logic        pcWrite, adrSrc, memWrite, irWrite, regWrite, retire, illegal;
    logic [1:0]  resultSrc, aluSrcA, aluSrcB, inmSrc;
    logic [2:0]  ALUControl;
    logic [31:0] instret;
    logic [15:0] act;

    int n_vec = 0;
    int n_err = 0;

    multicycle_controller #(.CNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .f3(f3), .f7(f7), .zero(zero),
        .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
        .resultSrc(resultSrc), .ALUControl(ALUControl), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .inmSrc(inmSrc), .regWrite(regWrite), .retire(retire),
        .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    assign act = {pcWrite, adrSrc, memWrite, irWrite, resultSrc, ALUControl,
                  aluSrcA, aluSrcB, regWrite, retire, illegal};

    // Expected control word, same field order as act.
    function automatic logic [15:0] mk(input logic pcw, adr, mw, irw, input logic [1:0] rs,
                                       input logic [2:0] alu, input logic [1:0] sa, sb,
                                       input logic rw, ret, ill);
        return {pcw, adr, mw, irw, rs, alu, sa, sb, rw, ret, ill};
    endfunction

    localparam logic [15:0] V_RST    = {1'b0,1'b0,1'b0,1'b0,2'b10,3'b000,2'b00,2'b10,1'b0,1'b0,1'b0};
    localparam logic [15:0] V_FETCH  = {1'b1,1'b0,1'b0,1'b1,2'b10,3'b000,2'b00,2'b10,1'b0,1'b0,1'b0};
    localparam logic [15:0] V_DECODE = {1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b01,2'b01,1'b0,1'b0,1'b0};
    localparam logic [15:0] V_MEMADR = {1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b10,2'b01,1'b0,1'b0,1'b0};
    localparam logic [15:0] V_MEMRD  = {1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,2'b00,2'b00,1'b0,1'b0,1'b0};
    localparam logic [15:0] V_MEMWB  = {1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,2'b00,2'b00,1'b1,1'b1,1'b0};
    localparam logic [15:0] V_MEMWR  = {1'b0,1'b1,1'b1,1'b0,2'b00,3'b000,2'b00,2'b00,1'b0,1'b1,1'b0};
    localparam logic [15:0] V_ALUWB  = {1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,2'b00,1'b1,1'b1,1'b0};
    localparam logic [15:0] V_JAL    = {1'b1,1'b0,1'b0,1'b0,2'b00,3'b000,2'b01,2'b10,1'b0,1'b0,1'b0};
    localparam logic [15:0] V_TRAP   = {1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,2'b00,1'b0,1'b0,1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample point is just after the falling edge.
    task automatic nxt();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Start an instruction from FETCH: load IR fields, check FETCH and DECODE.
    task automatic start(input string tag, input logic [6:0] o, input logic [2:0] f, input logic s7);
        op = o; f3 = f; f7 = s7;
        #1;
        chk({tag, "_fetch"}, 32'(act), 32'(V_FETCH));
        nxt();
        chk({tag, "_decode"}, 32'(act), 32'(V_DECODE));
    endtask

    initial begin
        reset = 1'b0; op = 7'b0000011; f3 = 3'b010; f7 = 1'b0; zero = 1'b0;
        #12;
        chk("reset_ctl", 32'(act), 32'(V_RST));
        chk("reset_instret", instret, 32'd0);

        // release on a falling edge so the first checks sit mid-cycle
        @(negedge clk);
        reset = 1'b1;
        #1;

        // lw: 5 cycles
        start("lw", 7'b0000011, 3'b010, 1'b0);
        chk("lw_imm", 32'(inmSrc), 32'd0);
        nxt(); chk("lw_memadr", 32'(act), 32'(V_MEMADR));
        nxt(); chk("lw_memread", 32'(act), 32'(V_MEMRD));
        nxt(); chk("lw_memwb", 32'(act), 32'(V_MEMWB));
        nxt(); chk("lw_instret", instret, 32'd1);

        // sw: 4 cycles
        start("sw", 7'b0100011, 3'b010, 1'b0);
        chk("sw_imm", 32'(inmSrc), 32'd1);
        nxt(); chk("sw_memadr", 32'(act), 32'(V_MEMADR));
        nxt(); chk("sw_memwrite", 32'(act), 32'(V_MEMWR));
        nxt(); chk("sw_instret", instret, 32'd2);

        // R-type sub
        start("rsub", 7'b0110011, 3'b000, 1'b1);
        nxt(); chk("rsub_exec", 32'(act), 32'(mk(0,0,0,0,2'b00,3'b001,2'b10,2'b00,0,0,0)));
        nxt(); chk("rsub_aluwb", 32'(act), 32'(V_ALUWB));
        nxt(); chk("rsub_instret", instret, 32'd3);

        // R-type add
        start("radd", 7'b0110011, 3'b000, 1'b0);
        nxt(); chk("radd_exec", 32'(act), 32'(mk(0,0,0,0,2'b00,3'b000,2'b10,2'b00,0,0,0)));
        nxt(); chk("radd_aluwb", 32'(act), 32'(V_ALUWB));
        nxt();

        // R-type and
        start("rand", 7'b0110011, 3'b111, 1'b0);
        nxt(); chk("rand_exec", 32'(ALUControl), 32'd2);
        nxt(); nxt(); chk("rand_instret", instret, 32'd5);

        // I-type addi with IR[30] set must still add
        start("addi", 7'b0010011, 3'b000, 1'b1);
        nxt(); chk("addi_exec", 32'(act), 32'(mk(0,0,0,0,2'b00,3'b000,2'b10,2'b01,0,0,0)));
        nxt(); chk("addi_aluwb", 32'(act), 32'(V_ALUWB));
        nxt();

        // I-type slti and ori
        start("slti", 7'b0010011, 3'b010, 1'b0);
        nxt(); chk("slti_exec", 32'(ALUControl), 32'd5);
        nxt(); nxt();
        start("ori", 7'b0010011, 3'b110, 1'b0);
        nxt(); chk("ori_exec", 32'(ALUControl), 32'd3);
        nxt(); nxt(); chk("ori_instret", instret, 32'd8);

        // beq taken / not taken: 3 cycles, both retire
        zero = 1'b1;
        start("beq1", 7'b1100011, 3'b000, 1'b0);
        chk("beq_imm", 32'(inmSrc), 32'd2);
        nxt(); chk("beq1_exec", 32'(act), 32'(mk(1,0,0,0,2'b00,3'b001,2'b10,2'b00,0,1,0)));
        nxt(); chk("beq1_instret", instret, 32'd9);
        zero = 1'b0;
        start("beq0", 7'b1100011, 3'b000, 1'b0);
        nxt(); chk("beq0_exec", 32'(act), 32'(mk(0,0,0,0,2'b00,3'b001,2'b10,2'b00,0,1,0)));
        nxt(); chk("beq0_instret", instret, 32'd10);

        // jal: 4 cycles, writeback of link via ALUOut
        start("jal", 7'b1101111, 3'b101, 1'b1);
        chk("jal_imm", 32'(inmSrc), 32'd3);
        nxt(); chk("jal_jal", 32'(act), 32'(V_JAL));
        nxt(); chk("jal_aluwb", 32'(act), 32'(V_ALUWB));
        nxt(); chk("jal_instret", instret, 32'd11);

        // reset mid-MEMREAD aborts and clears the counter immediately
        start("lwab", 7'b0000011, 3'b010, 1'b0);
        nxt(); nxt(); chk("lwab_memread", 32'(act), 32'(V_MEMRD));
        reset = 1'b0;
        #1;
        chk("abort_ctl", 32'(act), 32'(V_RST));
        chk("abort_instret", instret, 32'd0);
        nxt(); chk("abort_hold", 32'(act), 32'(V_RST));
        reset = 1'b1;

        // unknown opcode -> sticky TRAP
        start("bad", 7'b1111111, 3'b000, 1'b0);
        nxt(); chk("bad_trap", 32'(act), 32'(V_TRAP));
        for (int i = 0; i < 4; i++) begin
            nxt(); chk("bad_trap_hold", 32'(act), 32'(V_TRAP));
        end
        chk("bad_instret", instret, 32'd0);

        // R-type with unsupported funct3 -> TRAP
        reset = 1'b0;
        #1;
        chk("trap_reset", 32'(act), 32'(V_RST));
        nxt();
        reset = 1'b1;
        start("rbad", 7'b0110011, 3'b001, 1'b0);
        nxt(); chk("rbad_trap", 32'(act), 32'(V_TRAP));

        // lw with wrong width -> TRAP
        reset = 1'b0;
        #1;
        nxt();
        reset = 1'b1;
        start("lwbad", 7'b0000011, 3'b000, 1'b0);
        nxt(); chk("lwbad_trap", 32'(act), 32'(V_TRAP));
        chk("lwbad_instret", instret, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
